// File: rtl/ascii_seq_tx.sv
// ascii_seq_tx
// ------------
// Sequence transmitter that sits in front of an existing uart_tx instance.
// On an accepted start it emits the inclusive run of codes cfg_first..cfg_last
// (counting up, wrapping modulo 2^DATA_W) one character at a time. Each
// character is preceded by an idle gap of GAP_CYCLES clocks and then handed
// over through the uart_tx start/ready handshake. The run is either one-shot,
// ending with a done pulse, or repeats until abort.
//
// Optional feature macro: SEQ_NEWLINE_EN
//   When defined, every pass is followed by a CR (0x0D) and an LF (0x0A).
//   These use the same gap and handshake, and they count in char_count.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active low
//   start       in   level, sampled only while idle; launches a sequence
//   abort       in   synchronous abort, honoured in every state
//   cfg_first   in   first code (latched on accepted start)
//   cfg_last    in   last code (latched on accepted start)
//   cfg_repeat  in   1 = loop until abort (latched on accepted start)
//   tx_ready    in   from uart_tx: 1 = ready, 0 = busy
//   tx_data     out  character presented to uart_tx
//   tx_start    out  one-cycle request pulse to uart_tx
//   busy        out  high whenever the sequencer is not idle
//   done        out  one-cycle pulse at the end of a one-shot sequence
//   char_count  out  characters issued since the last accepted start
module ascii_seq_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_W      = 28,
  parameter int GAP_CYCLES = 25000000,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_first,
  input  logic [DATA_W-1:0] cfg_last,
  input  logic              cfg_repeat,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  char_count
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

`ifdef SEQ_NEWLINE_EN
  typedef enum logic [2:0] {
    IDLE, GAP, WAIT_RDY, WAIT_ACK, DONE, CR, LF
  } state_t;

  // Records which terminator, if any, the current gap/handshake round carries.
  typedef enum logic [1:0] {
    TERM_NONE, TERM_CR, TERM_LF
  } term_t;

  localparam logic [DATA_W-1:0] CR_CODE = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] LF_CODE = DATA_W'(8'h0A);

  term_t term_q, term_n;
`else
  typedef enum logic [2:0] {
    IDLE, GAP, WAIT_RDY, WAIT_ACK, DONE
  } state_t;
`endif

  state_t            state, state_n;
  logic [DATA_W-1:0] cur, cur_n;
  logic [DATA_W-1:0] first_q, first_n;
  logic [DATA_W-1:0] last_q, last_n;
  logic              rep_q, rep_n;
  logic [GAP_W-1:0]  timer, timer_n;
  logic [DATA_W-1:0] tx_data_n;
  logic              tx_start_n;
  logic              busy_n;
  logic              done_n;
  logic [CNT_W-1:0]  char_count_n;
  logic              pass_end;

  // State, latched configuration and all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cur        <= '0;
      first_q    <= '0;
      last_q     <= '0;
      rep_q      <= 1'b0;
      timer      <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      char_count <= '0;
`ifdef SEQ_NEWLINE_EN
      term_q     <= TERM_NONE;
`endif
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      first_q    <= first_n;
      last_q     <= last_n;
      rep_q      <= rep_n;
      timer      <= timer_n;
      tx_data    <= tx_data_n;
      tx_start   <= tx_start_n;
      busy       <= busy_n;
      done       <= done_n;
      char_count <= char_count_n;
`ifdef SEQ_NEWLINE_EN
      term_q     <= term_n;
`endif
    end
  end

  // Next-state and next-output logic. Abort overrides every state. It
  // leaves char_count and tx_data untouched and never requests a new
  // character.
  always_comb begin
    state_n      = state;
    cur_n        = cur;
    first_n      = first_q;
    last_n       = last_q;
    rep_n        = rep_q;
    timer_n      = timer;
    tx_data_n    = tx_data;
    tx_start_n   = 1'b0;
    char_count_n = char_count;
    pass_end     = 1'b0;
`ifdef SEQ_NEWLINE_EN
    term_n       = term_q;
`endif

    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            first_n      = cfg_first;
            last_n       = cfg_last;
            rep_n        = cfg_repeat;
            cur_n        = cfg_first;
            char_count_n = '0;
            timer_n      = GAP_LOAD;
            state_n      = GAP;
`ifdef SEQ_NEWLINE_EN
            term_n       = TERM_NONE;
`endif
          end
        end

        GAP: begin
          if (timer != '0) begin
            timer_n = timer - GAP_W'(1);
          end else begin
            state_n = WAIT_RDY;
          end
        end

        WAIT_RDY: begin
          if (tx_ready) begin
`ifdef SEQ_NEWLINE_EN
            case (term_q)
              TERM_CR: tx_data_n = CR_CODE;
              TERM_LF: tx_data_n = LF_CODE;
              default: tx_data_n = cur;
            endcase
`else
            tx_data_n    = cur;
`endif
            tx_start_n   = 1'b1;
            char_count_n = char_count + CNT_W'(1);
            state_n      = WAIT_ACK;
          end
        end

        // uart_tx drops ready once it has taken the character. Only then
        // do we move on, so tx_data stays stable for the whole handoff.
        WAIT_ACK: begin
          if (!tx_ready) begin
`ifdef SEQ_NEWLINE_EN
            if (term_q == TERM_CR) begin
              state_n = LF;
            end else if (term_q == TERM_LF) begin
              pass_end = 1'b1;
            end else if (cur != last_q) begin
              cur_n   = cur + DATA_W'(1);
              timer_n = GAP_LOAD;
              state_n = GAP;
            end else begin
              state_n = CR;
            end
`else
            if (cur != last_q) begin
              cur_n   = cur + DATA_W'(1);
              timer_n = GAP_LOAD;
              state_n = GAP;
            end else begin
              pass_end = 1'b1;
            end
`endif
          end
        end

        DONE: begin
          state_n = IDLE;
        end

`ifdef SEQ_NEWLINE_EN
        // Terminator rounds: select the character, then reuse the normal
        // gap and handshake path.
        CR: begin
          term_n  = TERM_CR;
          timer_n = GAP_LOAD;
          state_n = GAP;
        end

        LF: begin
          term_n  = TERM_LF;
          timer_n = GAP_LOAD;
          state_n = GAP;
        end
`endif

        default: begin
          state_n = IDLE;
        end
      endcase

      // End of a pass: restart from the latched first code, or finish.
      if (pass_end) begin
        if (rep_q) begin
          cur_n   = first_q;
          timer_n = GAP_LOAD;
          state_n = GAP;
`ifdef SEQ_NEWLINE_EN
          term_n  = TERM_NONE;
`endif
        end else begin
          state_n = DONE;
        end
      end
    end

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

endmodule

// File: doc/ascii_seq_tx.md
Name: ascii_seq_tx

Overview:
- Parametrised sequence transmitter: on `start`, emits an inclusive run of byte codes `cfg_first`..`cfg_last` through a `uart_tx`-style start/ready handshake.
- Inserts a programmable idle gap before each character.
- Supports one-shot or continuous repeat, and abort.
- Sits between control logic (buttons/host FSM) and the existing `uart_tx` instance; drives its `data`/`start` and consumes its `ready`.

Parameters:
- DATA_W, 8, character width in bits.
- GAP_W, 28, width of the inter-character gap counter.
- GAP_CYCLES, 25000000, clk cycles of idle before each character; 0 allowed; must fit in GAP_W bits.
- CNT_W, 16, width of `char_count`.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  level; sampled only in IDLE; launches a sequence
- abort  in  1  synchronous abort, any state
- cfg_first  in  DATA_W  first code; latched on accepted start
- cfg_last  in  DATA_W  last code; latched on accepted start
- cfg_repeat  in  1  1 = loop forever until abort; latched on accepted start
- tx_ready  in  1  from uart_tx: 1 = idle/ready, 0 = busy
- tx_data  out  DATA_W  character to transmit
- tx_start  out  1  one-cycle request pulse to uart_tx
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a one-shot sequence completes
- char_count  out  CNT_W  characters issued since last accepted start; wraps modulo 2^CNT_W

Behaviour:
- Reset values: state IDLE; tx_data=0; tx_start=0; busy=0; done=0; char_count=0; timer=0.
- Reset is honoured mid-operation: all outputs return to reset values immediately.
- All outputs are registered.
- IDLE:
  - start=1 and abort=0 → latch the three cfg inputs, cur←cfg_first, char_count←0, timer←GAP_CYCLES, go to GAP.
  - Otherwise stay in IDLE.
- GAP:
  - timer≠0 → timer decrements by 1.
  - timer=0 → go to WAIT_RDY.
  - With GAP_CYCLES=0, GAP lasts exactly one cycle.
- WAIT_RDY:
  - tx_ready=1 → tx_data←cur, tx_start=1 for exactly one cycle, char_count+1, go to WAIT_ACK.
  - tx_ready=0 → hold.
- WAIT_ACK:
  - Hold tx_data stable and wait for tx_ready=0, i.e. uart_tx has accepted the character.
  - Then, if cur≠last: cur←cur+1 (modulo 2^DATA_W), timer←GAP_CYCLES, go to GAP.
  - Then, if cur=last and repeat=1: cur←first, timer←GAP_CYCLES, go to GAP.
  - Then, if cur=last and repeat=0: go to DONE.
- DONE: done=1 for one cycle, go to IDLE.
- Wrap-around: first>last is legal. The sequence counts up through 2^DATA_W−1, wraps to 0, and ends at last. Example: FE,FF,00,01 for first=FE, last=01.
- first=last: exactly one character per pass.
- Latency:
  - From start sampled in IDLE to tx_start: GAP_CYCLES+2 cycles when tx_ready is already 1.
  - Minimum spacing between tx_start pulses: GAP_CYCLES+3 cycles, plus uart_tx busy time.
- abort:
  - Highest priority after reset; any state → IDLE on the next edge.
  - tx_start is forced 0 in that cycle; no done pulse.
  - char_count holds its value.
  - A character already accepted by uart_tx completes on the line.
- start held high:
  - A one-shot relaunches from IDLE in the cycle after DONE.
  - Changes to cfg while busy have no effect.
- tx_start is never asserted while tx_ready=0.

Optional Feature:
- Macro: SEQ_NEWLINE_EN.
- Defined: after the last code of each pass, two extra characters are sent, 0x0D then 0x0A (zero-extended to DATA_W).
  - Each uses the same gap and handshake and increments char_count.
  - Repeat or DONE decisions follow the 0x0A.
  - States CR and LF are added between WAIT_ACK and the repeat/DONE decision.
- Undefined: no terminator characters; state encoding excludes CR/LF.

Test Plan:
- One-shot digits: GAP_CYCLES=4, first=0x30, last=0x39, repeat=0, uart model with ready low 10 cycles per char.
  → tx_start pulses carry 30..39 in order; char_count=10; single done pulse; busy falls with done.
- Timing: GAP_CYCLES=0, tx_ready tied 1 then dropping one cycle after tx_start.
  → first tx_start exactly 2 cycles after start sampled; spacing between pulses matches the latency rule.
- Wrap and single-char: first=0xFE, last=0x01 → FE,FF,00,01 then done. first=last=0x41 → one 0x41 then done.
- Repeat + abort: first=0x61, last=0x63, repeat=1, run 7 characters.
  → sequence 61,62,63,61,62,63,61; abort asserted in GAP → IDLE next edge; no done; no further tx_start; char_count=7.
- Async reset mid-WAIT_ACK: rst low between edges.
  → all outputs 0 immediately; after release, no tx_start until a new start.
- SEQ_NEWLINE_EN defined, first=0x30, last=0x31, one-shot → 30,31,0D,0A; char_count=4; one done.
